seg_digit_scan_tx: RTL
======================

Name: seg_digit_scan_tx

Overview:
- Transmit-side counterpart of the drawn-segment number decoder. Takes four 5-bit number codes in the same code space: 0 = invalid/blank, 1..10 = digits 0..9, i.e. code = digit+1.
- Encodes each code into a 7-segment pattern using the same segment map: bit0 = a … bit6 = g.
- Time-multiplexes the four patterns onto the board's active-low anode/segment pins.
- Double-buffered load so a display update never tears mid-frame.

Parameters:
REFRESH_DIV, 100000, CLOCK cycles each digit is lit (1 kHz per digit at 100 MHz); legal range ≥2.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures codes and dp_mask into the pending buffer.
- codes  in  20  four codes; codes[4:0] = rightmost digit (an[0]), codes[19:15] = leftmost.
- dp_mask  in  4  decimal point request per digit; 1 = lit.
- seg  out  7  segment drive, active-low, seg[0] = a.
- dp  out  1  decimal point, active-low.
- an  out  4  anode select, active-low, one-hot-low.
- pending  out  1  high while a loaded frame awaits the next frame boundary.
- frame_tick  out  1  one-cycle pulse when the digit index wraps 3→0.

Behaviour:
- Reset values (asynchronous):
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - pending = 0, frame_tick = 0.
  - Refresh counter = 0, digit index = 0.
  - Active and pending buffers cleared; all codes 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - The cycle in which it wraps is a "tick". On a tick, index ← (index+1) mod 4.
- Frame boundary: a tick with index = 3.
  - index → 0 and frame_tick = 1 in the following cycle.
  - If pending = 1: active ← pending buffer and pending ← 0.
- Outputs are registered:
  - On every tick, an/seg/dp update in the same edge to the new index, using the post-boundary active buffer.
  - First lit output after reset: digit 0, REFRESH_DIV cycles after reset release. Outputs stay dark until then.
- Load handling:
  - load = 1 writes the pending buffer and sets pending = 1.
  - A load while pending = 1 overwrites the buffer; latest wins and no error is raised.
  - load in the same cycle as a boundary: the boundary transfers the old pending contents (if any). The new data goes into the pending buffer and waits for the next boundary.
- Display latency: a load becomes visible within 4·REFRESH_DIV+1 cycles.
- Encoding (active-high pattern; seg = its bitwise inverse):
  - 1→0111111, 2→0000110, 3→1011011, 4→1001111, 5→1100110.
  - 6→1101101, 7→1111101, 8→0000111, 9→1111111, 10→1101111.
  - 0 or 11..31 → 0000000 (blank). The anode is still driven.
- dp = ~dp_mask_active[index], independent of code validity.
- Reset mid-frame: outputs go dark immediately and any pending load is discarded.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: positions 3..1 holding code 1 (digit 0) are blanked while every more-significant position is code 1, 0, or invalid. Position 0 is never blanked. dp is unaffected.
- Undefined: every code is encoded literally, zeros included.

Decomposition:
- Shared package seg_pkg holds:
  - The 5-bit code type.
  - Constants CODE_BLANK = 0 and CODE_DIGIT0 = 1.
  - The ten 7-bit segment pattern constants.
  - The decoder reuses these constants.
- One combinational sub-module, seg_code_encode: 5-bit code → 7-bit active-high pattern plus a valid flag.
- Scanning, buffering and blanking stay in the top module.

Test Plan (REFRESH_DIV = 4):
- Reset, then release with no load → an = 1111 and seg = 1111111 for 4 cycles. Then an cycles 1110/1101/1011/0111 with seg = 1111111 throughout; frame_tick every 16 cycles.
- Load codes {10,4,2,1} (leftmost…rightmost) mid-frame → pending = 1 until the boundary.
  - Next frame: an = 1110 with seg = 1000000; an = 1101 with 1111001; an = 1011 with 0110000; an = 0111 with 0010000.
- Codes {0,12,31,5} → positions 3..1 show seg = 1111111 with their anode asserted; position 0 shows 0011001 (digit 4).
- Two loads 3 cycles apart within one frame → only the second set is displayed after the boundary; pending clears exactly at frame_tick.
- Load asserted on the boundary tick → the current frame keeps the old data, pending = 1, and the new data appears one frame later.
- With SEG_LEADING_ZERO_BLANK_EN, codes {1,1,3,1} → positions 3 and 2 are blank, position 1 shows 0100100 and position 0 shows 1000000. Without the macro, all four digits are lit.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared code space and 7-segment patterns for the number display path.
// Patterns are active-high, bit0 = a ... bit6 = g.
package seg_pkg;

  typedef logic [4:0] code_t;

  localparam code_t CODE_BLANK  = 5'd0;
  localparam code_t CODE_DIGIT0 = 5'd1;
  localparam code_t CODE_DIGIT9 = 5'd10;

  localparam logic [6:0] SEG_D0    = 7'b0111111;
  localparam logic [6:0] SEG_D1    = 7'b0000110;
  localparam logic [6:0] SEG_D2    = 7'b1011011;
  localparam logic [6:0] SEG_D3    = 7'b1001111;
  localparam logic [6:0] SEG_D4    = 7'b1100110;
  localparam logic [6:0] SEG_D5    = 7'b1101101;
  localparam logic [6:0] SEG_D6    = 7'b1111101;
  localparam logic [6:0] SEG_D7    = 7'b0000111;
  localparam logic [6:0] SEG_D8    = 7'b1111111;
  localparam logic [6:0] SEG_D9    = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    code_t [3:0] code;
    logic  [3:0] dp;
  } frame_t;

  // A position that lets a less-significant zero stay blank.
  function automatic logic code_is_lead(input code_t c);
    return (c == CODE_DIGIT0) || (c == CODE_BLANK) || (c > CODE_DIGIT9);
  endfunction

endpackage

// File: rtl/seg_code_encode.sv
// seg_code_encode: 5-bit number code to active-high 7-segment pattern.
// Codes outside 1..10 give a blank pattern and valid = 0.
module seg_code_encode
  import seg_pkg::*;
(
  input  code_t      code,
  output logic [6:0] pattern,
  output logic       valid
);

  // Table lookup; code = digit + 1.
  always_comb begin
    pattern = SEG_BLANK;
    valid   = 1'b1;
    case (code)
      5'd1:    pattern = SEG_D0;
      5'd2:    pattern = SEG_D1;
      5'd3:    pattern = SEG_D2;
      5'd4:    pattern = SEG_D3;
      5'd5:    pattern = SEG_D4;
      5'd6:    pattern = SEG_D5;
      5'd7:    pattern = SEG_D6;
      5'd8:    pattern = SEG_D7;
      5'd9:    pattern = SEG_D8;
      5'd10:   pattern = SEG_D9;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_digit_scan_tx.sv
// seg_digit_scan_tx: double-buffered 4-digit scan driver, active-low pins.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zeros on positions 3..1.
module seg_digit_scan_tx
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        load,
  input  logic [19:0] codes,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          lit;
  logic          tick;
  logic          start;
  logic          wrap;
  logic          xfer;
  logic [1:0]    idx_nxt;
  frame_t        in_frame;
  frame_t        act_q;
  frame_t        pend_q;
  frame_t        act_nxt;
  code_t         sel_code;
  logic [6:0]    pat;
  logic          pat_ok;
  logic [3:0]    blank;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic          dp_d;

  assign tick  = (cnt == LAST);
  assign wrap  = tick && lit && (idx == 2'd3);
  assign start = tick && (!lit || (idx == 2'd3));
  assign xfer  = start && pending;

  assign idx_nxt = lit ? idx + 2'd1 : 2'd0;

  assign in_frame.code = codes;
  assign in_frame.dp   = dp_mask;

  assign act_nxt  = xfer ? pend_q : act_q;
  assign sel_code = act_nxt.code[idx_nxt];

  seg_code_encode u_enc (
    .code    (sel_code),
    .pattern (pat),
    .valid   (pat_ok)
  );

  // Leading-zero mask for the frame about to be shown.
  always_comb begin
    blank = 4'b0000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank[3] = act_nxt.code[3] == CODE_DIGIT0;
    blank[2] = (act_nxt.code[2] == CODE_DIGIT0)
            && code_is_lead(act_nxt.code[3]);
    blank[1] = (act_nxt.code[1] == CODE_DIGIT0)
            && code_is_lead(act_nxt.code[3])
            && code_is_lead(act_nxt.code[2]);
`endif
  end

  // Next pin values for the digit selected on this tick.
  always_comb begin
    seg_d = 7'b1111111;
    if (pat_ok && !blank[idx_nxt])
      seg_d = ~pat;
    an_d = ~(4'b0001 << idx_nxt);
    dp_d = ~act_nxt.dp[idx_nxt];
  end

  // Refresh counter and digit index; first tick lights digit 0.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt        <= '0;
      idx        <= 2'd0;
      lit        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (tick) begin
        cnt <= '0;
        idx <= idx_nxt;
        lit <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pending/active buffers; a load on a boundary waits one frame.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      act_q   <= '0;
      pend_q  <= '0;
      pending <= 1'b0;
    end else begin
      if (xfer)
        act_q <= pend_q;
      if (load) begin
        pend_q  <= in_frame;
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered pins, dark until the first tick.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else if (tick) begin
      seg <= seg_d;
      an  <= an_d;
      dp  <= dp_d;
    end
  end

endmodule
